// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA3-256 padding / chunk packing front end.
package sha3_pkg;

    localparam int unsigned RATE_BYTES = 136;
    localparam int unsigned RATE_LANES = 17;
    localparam int unsigned CHUNK_W    = 200;
    localparam int unsigned NUM_CHUNKS = 8;
    localparam int unsigned LANE_W     = 64;

    localparam logic [7:0] PAD_DS  = 8'h06;
    localparam logic [7:0] PAD_END = 8'h80;

    typedef logic [1:0] state_t;
    localparam state_t FILL = 2'd0;
    localparam state_t EMIT = 2'd1;
    localparam state_t PAD  = 2'd2;

    typedef logic [63:0] lane_t;

endpackage

// File: rtl/sha3_pad_lane.sv
// Keeps bytes 0..n-1 of a lane, zeroes the rest and optionally drops the
// 0x06 domain byte at byte n (n=8 means no room in this lane).
module sha3_pad_lane
    import sha3_pkg::*;
(
    input  lane_t      din,
    input  logic [3:0] n,
    input  logic       padflag,
    output lane_t      dout
);

    always_comb begin
        dout = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < n) begin
                dout[8*b +: 8] = din[8*b +: 8];
            end else if (padflag && (4'(b) == n)) begin
                dout[8*b +: 8] = PAD_DS;
            end
        end
    end

endmodule

// File: rtl/sha3_pad_pack.sv
// SHA3-256 padder: packs 64-bit message words into rate blocks and streams
// each 1600-bit state out as NUM_CHUNKS chunks, capacity forced to zero.
module sha3_pad_pack
    import sha3_pkg::*;
#(
    parameter int unsigned RATE_LANES = sha3_pkg::RATE_LANES,
    parameter int unsigned CHUNK_W    = sha3_pkg::CHUNK_W,
    parameter int unsigned NUM_CHUNKS = sha3_pkg::NUM_CHUNKS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pushin,
    input  logic [63:0]        din,
    input  logic [3:0]         bytesin,
    input  logic               lastin,
    output logic               stopin,
    output logic [2:0]         doutix,
    output logic [CHUNK_W-1:0] dout,
    output logic               pushout,
    output logic               lastout
);

    localparam int unsigned RATE_W  = RATE_LANES * LANE_W;
    localparam int unsigned STATE_W = CHUNK_W * NUM_CHUNKS;
    localparam int unsigned END_LSB = RATE_W - 8;
    localparam int unsigned WCNT_W  = 5;
    localparam logic [WCNT_W-1:0] LAST_LANE  = WCNT_W'(RATE_LANES - 1);
    localparam logic [2:0]        LAST_CHUNK = 3'(NUM_CHUNKS - 1);

    function automatic logic [CHUNK_W-1:0] chunk_of(input logic [RATE_W-1:0] r,
                                                     input logic [2:0] ix);
        logic [STATE_W-1:0] full;
        full = STATE_W'(r);
        return full[int'(ix)*CHUNK_W +: CHUNK_W];
    endfunction

    state_t              state_q, state_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                fin_q, fin_d;
    logic                pend_q, pend_d;
    logic                stopin_d, pushout_d, lastout_d, load;
    logic [2:0]          doutix_d;
    logic [CHUNK_W-1:0]  dout_d;
    logic [3:0]          n;
    lane_t               word_lane, next_lane;

    // Non-final words always carry 8 bytes; oversized counts clamp to 8.
    assign n = !lastin ? 4'd8 : ((bytesin > 4'd8) ? 4'd8 : bytesin);

    sha3_pad_lane u_word (.din(din), .n(n),    .padflag(lastin), .dout(word_lane));
    sha3_pad_lane u_next (.din('0),  .n(4'd0), .padflag(1'b1),   .dout(next_lane));

    always_comb begin
        state_d   = state_q;
        rate_d    = rate_q;
        wcnt_d    = wcnt_q;
        cnt_d     = cnt_q;
        fin_d     = fin_q;
        pend_d    = pend_q;
        pushout_d = 1'b0;
        lastout_d = 1'b0;
        doutix_d  = doutix;
        dout_d    = dout;
        load      = 1'b0;

        case (state_q)
            FILL: begin
                if (pushin) begin
                    rate_d[int'(wcnt_q)*LANE_W +: LANE_W] = word_lane;
                    if (lastin) begin
                        load = 1'b1;
                        if (n < 4'd8) begin
                            rate_d[END_LSB +: 8] = rate_d[END_LSB +: 8] ^ PAD_END;
                            fin_d  = 1'b1;
                            pend_d = 1'b0;
                        end else if (wcnt_q == LAST_LANE) begin
                            // Full final lane: padding spills into a second block.
                            fin_d  = 1'b0;
                            pend_d = 1'b1;
                        end else begin
                            rate_d[(int'(wcnt_q)+1)*LANE_W +: LANE_W] = next_lane;
                            rate_d[END_LSB +: 8] = rate_d[END_LSB +: 8] ^ PAD_END;
                            fin_d  = 1'b1;
                            pend_d = 1'b0;
                        end
                    end else if (wcnt_q == LAST_LANE) begin
                        load   = 1'b1;
                        fin_d  = 1'b0;
                        pend_d = 1'b0;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            EMIT: begin
                if (cnt_q == LAST_CHUNK) begin
                    rate_d  = '0;
                    wcnt_d  = '0;
                    state_d = pend_q ? PAD : FILL;
                end else begin
                    cnt_d     = cnt_q + 3'd1;
                    pushout_d = 1'b1;
                    doutix_d  = cnt_q + 3'd1;
                    dout_d    = chunk_of(rate_q, cnt_q + 3'd1);
                    lastout_d = fin_q && ((cnt_q + 3'd1) == LAST_CHUNK);
                end
            end
            PAD: begin
                rate_d                 = '0;
                rate_d[LANE_W-1:0]     = next_lane;
                rate_d[END_LSB +: 8]   = rate_d[END_LSB +: 8] ^ PAD_END;
                fin_d                  = 1'b1;
                pend_d                 = 1'b0;
                load                   = 1'b1;
            end
            default: state_d = FILL;
        endcase

        // Chunk 0 leaves on the same edge the block is completed.
        if (load) begin
            state_d   = EMIT;
            cnt_d     = 3'd0;
            pushout_d = 1'b1;
            doutix_d  = 3'd0;
            dout_d    = chunk_of(rate_d, 3'd0);
        end

        stopin_d = (state_d != FILL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            rate_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            pend_q  <= 1'b0;
            stopin  <= 1'b0;
            pushout <= 1'b0;
            lastout <= 1'b0;
            doutix  <= '0;
            dout    <= '0;
        end else begin
            state_q <= state_d;
            rate_q  <= rate_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            pend_q  <= pend_d;
            stopin  <= stopin_d;
            pushout <= pushout_d;
            lastout <= lastout_d;
            doutix  <= doutix_d;
            dout    <= dout_d;
        end
    end

endmodule

// File: tb/tb_sha3_pad_pack.sv
// Directed self-checking bench for sha3_pad_pack: hand-built padded blocks
// compared chunk by chunk, plus latency, stall, drop and reset behaviour.
module tb_sha3_pad_pack;

    logic         clk = 1'b0;
    logic         reset;
    logic         pushin;
    logic [63:0]  din;
    logic [3:0]   bytesin;
    logic         lastin;
    logic         stopin;
    logic [2:0]   doutix;
    logic [199:0] dout;
    logic         pushout;
    logic         lastout;

    int checks   = 0;
    int failures = 0;

    logic [199:0]  got [8];
    logic [7:0]    got_last;
    int            first_wait;
    logic [1599:0] exp_st;

    always #5 clk = ~clk;

    sha3_pad_pack dut (
        .clk(clk), .reset(reset), .pushin(pushin), .din(din), .bytesin(bytesin),
        .lastin(lastin), .stopin(stopin), .doutix(doutix), .dout(dout),
        .pushout(pushout), .lastout(lastout)
    );

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge; the word is sampled on the rising edge between.
    task automatic push(input logic [63:0] w, input logic [3:0] b, input logic l);
        pushin  = 1'b1;
        din     = w;
        bytesin = b;
        lastin  = l;
        @(negedge clk);
        pushin  = 1'b0;
        lastin  = 1'b0;
    endtask

    // Waits (bounded) for chunk 0, then records 8 consecutive chunks.
    task automatic capture(input string tag);
        int t;
        t = 0;
        while (pushout !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        first_wait = t;
        check($sformatf("%s started", tag), 200'(t < 20), 200'(1));
        got_last = '0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s ix%0d", tag, i), 200'(doutix), 200'(i));
            check($sformatf("%s push/stop%0d", tag, i), 200'({pushout, stopin}), 200'(2'b11));
            got[i]      = dout;
            got_last[i] = lastout;
            @(negedge clk);
        end
    endtask

    task automatic check_block(input string tag, input logic [1599:0] e, input logic [7:0] el);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s chunk%0d", tag, i), got[i], e[i*200 +: 200]);
        check($sformatf("%s lastout", tag), 200'(got_last), 200'(el));
    endtask

    initial begin
        reset   = 1'b1;
        pushin  = 1'b0;
        din     = '0;
        bytesin = '0;
        lastin  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset dout", dout, 200'(0));
        check("reset ctl", 200'({pushout, lastout, stopin, doutix}), 200'(0));

        // Empty message
        push(64'h0, 4'd0, 1'b1);
        capture("empty");
        check("empty latency", 200'(first_wait), 200'(0));
        exp_st = '0;
        exp_st[7:0] = 8'h06;
        exp_st[1087] = 1'b1;
        check_block("empty", exp_st, 8'h80);
        check("empty idle", 200'({pushout, lastout, stopin}), 200'(0));

        // "abc"
        push(64'h636261, 4'd3, 1'b1);
        capture("abc");
        check("abc latency", 200'(first_wait), 200'(0));
        exp_st = '0;
        exp_st[31:0] = 32'h06636261;
        exp_st[1087] = 1'b1;
        check_block("abc", exp_st, 8'h80);

        // 135 bytes: pad and end marker share byte 135; bytesin ignored on non-last words
        exp_st = '0;
        for (int i = 0; i < 16; i++) begin
            push({8{8'(i + 1)}}, 4'd0, 1'b0);
            exp_st[i*64 +: 64] = {8{8'(i + 1)}};
        end
        push(64'hFFEEDDCCBBAA9988, 4'd7, 1'b1);
        exp_st[16*64 +: 64] = 64'h86EEDDCCBBAA9988;
        capture("b135");
        check_block("b135", exp_st, 8'h80);

        // 136 bytes: full block without padding, then a pad-only block
        exp_st = '0;
        for (int i = 0; i < 17; i++) begin
            push({8{8'(i + 8'h11)}}, 4'd8, (i == 16) ? 1'b1 : 1'b0);
            exp_st[i*64 +: 64] = {8{8'(i + 8'h11)}};
        end
        capture("b136a");
        check("b136a latency", 200'(first_wait), 200'(0));
        check_block("b136a", exp_st, 8'h00);
        check("b136 pad cycle", 200'({pushout, stopin}), 200'(2'b01));
        capture("b136b");
        check("b136b latency", 200'(first_wait), 200'(1));
        exp_st = '0;
        exp_st[7:0] = 8'h06;
        exp_st[1087] = 1'b1;
        check_block("b136b", exp_st, 8'h80);
        check("b136 stopin low", 200'(stopin), 200'(0));

        // Push held high throughout EMIT must be dropped
        pushin  = 1'b1;
        din     = 64'h4241;
        bytesin = 4'd2;
        lastin  = 1'b1;
        @(negedge clk);
        din     = 64'hDEADBEEFDEADBEEF;
        bytesin = 4'd5;
        capture("drop");
        pushin  = 1'b0;
        lastin  = 1'b0;
        exp_st = '0;
        exp_st[23:0] = 24'h064241;
        exp_st[1087] = 1'b1;
        check_block("drop", exp_st, 8'h80);
        push(64'h7a7978, 4'd3, 1'b1);
        capture("after drop");
        exp_st = '0;
        exp_st[31:0] = 32'h067a7978;
        exp_st[1087] = 1'b1;
        check_block("after drop", exp_st, 8'h80);

        // Reset in the middle of EMIT
        push(64'h1111, 4'd2, 1'b1);
        begin
            int t;
            t = 0;
            while (doutix !== 3'd3 && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("reach ix3", 200'(t < 20), 200'(1));
        end
        reset = 1'b1;
        @(negedge clk);
        check("midreset ctl", 200'({pushout, lastout, stopin}), 200'(0));
        check("midreset dout", dout, 200'(0));
        reset = 1'b0;
        push(64'h333231, 4'd3, 1'b1);
        capture("post reset");
        check("post reset latency", 200'(first_wait), 200'(0));
        exp_st = '0;
        exp_st[31:0] = 32'h06333231;
        exp_st[1087] = 1'b1;
        check_block("post reset", exp_st, 8'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
